// File: rtl/timer_pkg.sv
// timer_pkg
//   Shared types and constants for the count/match/reload timer controller.
//   - tmr_state_e   : controller state (IDLE / ARMED / DONE)
//   - MODE_ONESHOT  : cfg_periodic value selecting a single match then DONE
//   - MODE_PERIODIC : cfg_periodic value selecting reload-on-match
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } tmr_state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/count_match_timer_if.sv
// count_match_timer_if
//   Bundles every signal between the timer controller and its environment
//   (counter, configuration writer, interrupt logic).
//   Signal protocol: there is no valid/ready handshake anywhere on this bus.
//   Every input is level-sampled on each rising clock edge; start, stop,
//   irq_clr and cfg_we are single-cycle strobes, load and match_pulse are
//   single-cycle strobes from the controller, pl is meaningful while load=1.
//   Ports (direction as seen by the controller / slave modport):
//     count        in   N      current counter value
//     cfg_we       in   1      write cfg_* into shadow registers
//     cfg_cmp      in   N      compare value
//     cfg_reload   in   N      reload value
//     cfg_periodic in   1      1 = periodic, 0 = one-shot
//     start/stop   in   1      arm / disarm strobes
//     irq_clr      in   1      clear sticky irq
//     load, pl     out  1/N    counter reload strobe and value
//     match_pulse  out  1      one pulse per match
//     irq          out  1      sticky match flag
//     busy         out  1      controller is ARMED
//     evt_cnt      out  EVT_W  saturating match count since start
//     state_dbg    out  2      current controller state (debug)
interface count_match_timer_if #(
  parameter int N     = 32,
  parameter int EVT_W = 8
) ();
  import timer_pkg::*;

  logic [N-1:0]     count;
  logic             cfg_we;
  logic [N-1:0]     cfg_cmp;
  logic [N-1:0]     cfg_reload;
  logic             cfg_periodic;
  logic             start;
  logic             stop;
  logic             irq_clr;
  logic             load;
  logic [N-1:0]     pl;
  logic             match_pulse;
  logic             irq;
  logic             busy;
  logic [EVT_W-1:0] evt_cnt;
  tmr_state_e       state_dbg;

  modport master (
    output count, cfg_we, cfg_cmp, cfg_reload, cfg_periodic, start, stop, irq_clr,
    input  load, pl, match_pulse, irq, busy, evt_cnt, state_dbg
  );

  modport slave (
    input  count, cfg_we, cfg_cmp, cfg_reload, cfg_periodic, start, stop, irq_clr,
    output load, pl, match_pulse, irq, busy, evt_cnt, state_dbg
  );

endinterface

// File: rtl/sat_counter.sv
// sat_counter
//   W-bit up counter with synchronous clear. Saturation is decided by the
//   caller: it sees sat and simply stops pulsing inc once sat is high.
//   Ports:
//     clk, rst  in   1   clock, synchronous active-high reset
//     clr       in   1   clear to zero (wins over inc)
//     inc       in   1   increment by one
//     value     out  W   current count
//     sat       out  1   value is all ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         sat
);

  assign sat = &value;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/count_match_timer.sv
// count_match_timer
//   Compare/reload controller for an external up counter. While ARMED it
//   compares count against the active compare value; a hit produces a
//   match_pulse, sets the sticky irq and bumps evt_cnt. In periodic mode the
//   hit also reloads the counter and refreshes the active registers from the
//   shadow registers; in one-shot mode the controller goes DONE.
//   Ports:
//     clk   in  1   clock
//     rst   in  1   synchronous active-high reset
//     bus   slave modport of count_match_timer_if (see interface header)
module count_match_timer
  import timer_pkg::*;
#(
  parameter int N     = 32,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  count_match_timer_if.slave bus
);

  tmr_state_e       state_q, state_d;

  logic [N-1:0]     sh_cmp, sh_reload;
  logic             sh_per;
  logic [N-1:0]     act_cmp, act_reload;
  logic             act_per;

  logic             load_q, load_d;
  logic [N-1:0]     pl_q, pl_d;
  logic             match_q, match_d;
  logic             irq_q;
  logic             busy_q;

  logic             hit;
  logic             copy;
  logic             evt_clr;
  logic             evt_inc;
  logic             evt_sat;
  logic [EVT_W-1:0] evt_value;

  // While load_q is high the counter has not taken the reload yet, so count
  // still shows the value that just matched; masking that cycle prevents a
  // second match on the same count.
  assign hit = (state_q == ARMED) && !load_q && (bus.count == act_cmp);

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    pl_d    = pl_q;
    match_d = 1'b0;
    copy    = 1'b0;
    evt_clr = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.start) begin
      // Arm (or restart): the shadow value copied this edge is also the
      // reload value handed to the counter.
      state_d = ARMED;
      copy    = 1'b1;
      load_d  = 1'b1;
      pl_d    = sh_reload;
      evt_clr = 1'b1;
    end else if (hit) begin
      match_d = 1'b1;
      if (act_per == MODE_PERIODIC) begin
        load_d = 1'b1;
        pl_d   = act_reload;
        copy   = 1'b1;
      end else begin
        state_d = DONE;
      end
    end
  end

  assign evt_inc = match_d && !evt_sat;

  sat_counter #(.W(EVT_W)) u_evt (
    .clk   (clk),
    .rst   (rst),
    .clr   (evt_clr),
    .inc   (evt_inc),
    .value (evt_value),
    .sat   (evt_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_cmp     <= '0;
      sh_reload  <= '0;
      sh_per     <= MODE_ONESHOT;
      act_cmp    <= '0;
      act_reload <= '0;
      act_per    <= MODE_ONESHOT;
      load_q     <= 1'b0;
      pl_q       <= '0;
      match_q    <= 1'b0;
      irq_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      pl_q    <= pl_d;
      match_q <= match_d;
      busy_q  <= (state_d == ARMED);
      // Non-blocking update: a copy in the same cycle as cfg_we takes the
      // old shadow contents.
      if (copy) begin
        act_cmp    <= sh_cmp;
        act_reload <= sh_reload;
        act_per    <= sh_per;
      end
      if (bus.cfg_we) begin
        sh_cmp    <= bus.cfg_cmp;
        sh_reload <= bus.cfg_reload;
        sh_per    <= bus.cfg_periodic;
      end
      if (match_d) begin
        irq_q <= 1'b1;
      end else if (bus.irq_clr) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign bus.load        = load_q;
  assign bus.pl          = pl_q;
  assign bus.match_pulse = match_q;
  assign bus.irq         = irq_q;
  assign bus.busy        = busy_q;
  assign bus.evt_cnt     = evt_value;
  assign bus.state_dbg   = state_q;

endmodule
